pps_qualifier: RTL and testbench
================================

Name: pps_qualifier

Overview:
- Upstream neighbour of the PPS delay stage. Takes the raw PPS from the atomic/GPS reference and checks every interval against the local clock.
- Emits a clean, fixed-width PPS only when the reference is locked. On a missing edge it synthesizes PPS in holdover, so the nixie time chain never skips a second.
- Also exports lock/holdover status, the last measured interval and error counters for the Pi interface.

Parameters:
- CLKS_PER_SEC, 16667: nominal clk cycles between PPS edges.
- TOL, 17: allowed deviation (cycles) from CLKS_PER_SEC.
- LOCK_COUNT, 4: consecutive good intervals needed to lock.
- PULSE_W, 500: pps_out high time in cycles. Must satisfy PULSE_W < CLKS_PER_SEC-TOL.
- CNT_W, 20: interval counter width.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- pps_raw  in  1  raw PPS, asynchronous to clk
- pps_out  out  1  qualified/synthesized PPS, high PULSE_W cycles
- locked  out  1  state==LOCKED
- holdover  out  1  state==HOLDOVER
- last_interval  out  CNT_W  cycles between the last two accepted real edges
- glitch_cnt  out  8  early edges rejected while LOCKED, saturating
- miss_cnt  out  8  missing-edge timeouts, saturating

Behaviour:
Reset: one clock; reset is asynchronous and active-high. Asserting rst clears every flop regardless of clk:
- pps_out=0, locked=0, holdover=0, last_interval=0, glitch_cnt=0, miss_cnt=0
- state=ACQUIRE, cnt=0, good_cnt=0, have_ref=0
- A reset mid-pulse truncates the pulse immediately.

Input path and edge detection:
- pps_raw passes a 2-FF synchronizer (s1, s2), then a delay flop s3. edge = s2 & ~s3.
- Latency from pps_raw rising to edge is 3 clk. pps_out rises 1 clk after edge (4 clk total).

Interval counter (cnt):
- Increments every cycle and saturates at all-ones.
- On an accepted edge (see FSM), last_interval<=cnt and cnt<=1. Two edges N cycles apart therefore capture N.
- in_window = (CLKS_PER_SEC-TOL <= cnt <= CLKS_PER_SEC+TOL).

FSM:
- ACQUIRE: no pulses.
  - First edge: have_ref<=1, accept (restart cnt), good_cnt=0.
  - Subsequent edge: accept. If in_window, good_cnt++; else good_cnt<=0.
  - When good_cnt reaches LOCK_COUNT on an accepted edge: emit a pulse on that edge and go to LOCKED.
- LOCKED:
  - Edge with in_window: accept, emit pulse.
  - Edge with cnt < CLKS_PER_SEC-TOL: glitch. It is ignored, cnt is not restarted, glitch_cnt++.
  - cnt == CLKS_PER_SEC+TOL+1: timeout. Emit synthetic pulse, miss_cnt++, cnt<=TOL+2 (keeps nominal phase), go to HOLDOVER.
  - An edge in the same cycle as the timeout is discarded; the timeout wins.
- HOLDOVER:
  - cnt == CLKS_PER_SEC: emit synthetic pulse, cnt<=1.
  - Any real edge: accept, good_cnt<=0, go to ACQUIRE.
  - If the edge coincides with a synthetic pulse, the pulse still completes.

Pulse generator:
- A trigger while idle sets pps_out for exactly PULSE_W cycles.
- A trigger while active is ignored. This is unreachable given the parameter constraint and is assert-checked.

Counters:
- glitch_cnt and miss_cnt hold at 255.

Decomposition:
- Shared package pps_pkg:
  - state enum {ACQUIRE, LOCKED, HOLDOVER} (2 bits)
  - CNT_W
  - default CLKS_PER_SEC/TOL constants, shared with the delay stage so both agree on tick rate.
- Sub-module pps_pulse_gen (trigger in, PULSE_W-cycle pulse out, busy). It is reusable by the delay stage.
- Synchronizer/edge detect stays inline.

Test Plan:
Bench parameters: CLKS_PER_SEC=100, TOL=2, LOCK_COUNT=3, PULSE_W=10.
1. Lock: edges every 100 clk. locked rises on the 4th edge (3 good intervals). pps_out is high 10 clk starting 4 clk after each pps_raw rise from the 4th edge on. last_interval=100.
2. Window edges: in LOCKED, an interval of 98 and of 102 is accepted. An interval of 97 counts as a glitch: glitch_cnt=1, no pulse, and the next edge at 100 from the prior accepted edge is accepted.
3. Missing edge: stop pps_raw after lock. A synthetic pulse fires at cnt=103, holdover=1, miss_cnt=1. Further pulses follow every 100 clk, phase-aligned to the nominal edge.
4. Recovery: edge during HOLDOVER goes to ACQUIRE and pulses stop. 3 good intervals later locked=1 again.
5. Bad acquisition: intervals 100, 100, 120, 100, 100, 100 lock only after the final edge (good_cnt reset by 120).
6. Async reset mid-pulse: assert rst 3 clk into a pulse. pps_out=0 and all status is cleared immediately. After release, the first edge yields no pulse.

Source files
------------

// File: rtl/pps_pkg.sv
// Shared PPS definitions: qualifier state encoding, counter width and
// the default tick rate agreed between the qualifier and the delay stage.
package pps_pkg;

    typedef enum logic [1:0] {
        ACQUIRE  = 2'd0,
        LOCKED   = 2'd1,
        HOLDOVER = 2'd2
    } pps_state_e;

    localparam int CNT_W            = 20;
    localparam int CLKS_PER_SEC_DEF = 16667;
    localparam int TOL_DEF          = 17;

    // Saturating 8-bit increment for the status counters.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/pps_qualifier_if.sv
// PPS qualifier bus: raw reference in, clean PPS and status out.
// master: qualifier side (pps_raw in; pps_out, locked, holdover,
// last_interval, glitch_cnt, miss_cnt out). slave: consumer side.
interface pps_qualifier_if #(
    parameter int CNT_W = pps_pkg::CNT_W
);
    logic             pps_raw;
    logic             pps_out;
    logic             locked;
    logic             holdover;
    logic [CNT_W-1:0] last_interval;
    logic [7:0]       glitch_cnt;
    logic [7:0]       miss_cnt;

    modport master (
        input  pps_raw,
        output pps_out,
        output locked,
        output holdover,
        output last_interval,
        output glitch_cnt,
        output miss_cnt
    );

    modport slave (
        output pps_raw,
        input  pps_out,
        input  locked,
        input  holdover,
        input  last_interval,
        input  glitch_cnt,
        input  miss_cnt
    );
endinterface

// File: rtl/pps_pulse_gen.sv
// Fixed-width pulse generator: a trigger while idle produces a pulse
// exactly PULSE_W cycles wide. Ports: clk, rst, trig_i, pulse_o, busy_o.
module pps_pulse_gen #(
    parameter int PULSE_W = 500
) (
    input  logic clk,
    input  logic rst,
    input  logic trig_i,
    output logic pulse_o,
    output logic busy_o
);
    localparam int LW = $clog2(PULSE_W + 1);

    logic          active_q, active_d;
    logic [LW-1:0] left_q, left_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_q <= 1'b0;
            left_q   <= '0;
        end else begin
            active_q <= active_d;
            left_q   <= left_d;
        end
    end

    // left_q counts the remaining high cycles after the current one.
    always_comb begin
        active_d = active_q;
        left_d   = left_q;
        if (active_q) begin
            if (left_q == '0) begin
                active_d = 1'b0;
            end else begin
                left_d = left_q - LW'(1);
            end
        end else if (trig_i) begin
            active_d = 1'b1;
            left_d   = LW'(PULSE_W - 1);
        end
    end

    assign pulse_o = active_q;
    assign busy_o  = active_q;

    a_no_retrigger: assert property (
        @(posedge clk) disable iff (rst) !(trig_i && active_q)
    );

endmodule

// File: rtl/pps_qualifier.sv
// Qualifies the raw reference PPS against the local clock, locks after
// LOCK_COUNT good intervals, and free-runs in holdover on missing edges.
// Ports: clk, rst, bus (pps_raw in; pulse, lock/holdover and stats out).
module pps_qualifier #(
    parameter int CLKS_PER_SEC = pps_pkg::CLKS_PER_SEC_DEF,
    parameter int TOL          = pps_pkg::TOL_DEF,
    parameter int LOCK_COUNT   = 4,
    parameter int PULSE_W      = 500,
    parameter int CNT_W        = pps_pkg::CNT_W
) (
    input  logic            clk,
    input  logic            rst,
    pps_qualifier_if.master bus
);
    import pps_pkg::*;

    localparam int GOOD_W = $clog2(LOCK_COUNT + 1);

    localparam logic [CNT_W-1:0] WIN_LO  = CNT_W'(CLKS_PER_SEC - TOL);
    localparam logic [CNT_W-1:0] WIN_HI  = CNT_W'(CLKS_PER_SEC + TOL);
    localparam logic [CNT_W-1:0] T_OUT   = CNT_W'(CLKS_PER_SEC + TOL + 1);
    localparam logic [CNT_W-1:0] T_RLD   = CNT_W'(TOL + 2);
    localparam logic [CNT_W-1:0] NOMINAL = CNT_W'(CLKS_PER_SEC);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [GOOD_W-1:0] LOCK_N = GOOD_W'(LOCK_COUNT);

    logic s1_q, s2_q, s3_q;
    logic edge_det;

    pps_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [GOOD_W-1:0] good_q, good_d, good_inc;
    logic             have_q, have_d;
    logic [CNT_W-1:0] last_q, last_d;
    logic [7:0]       glitch_q, glitch_d;
    logic [7:0]       miss_q, miss_d;
    logic             trig_q, trig_d;
    logic             in_window;
    logic             pulse, pulse_busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= bus.pps_raw;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign edge_det  = s2_q & ~s3_q;
    assign cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + ONE;
    assign good_inc  = good_q + GOOD_W'(1);
    assign in_window = (cnt_q >= WIN_LO) && (cnt_q <= WIN_HI);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ACQUIRE;
            cnt_q    <= '0;
            good_q   <= '0;
            have_q   <= 1'b0;
            last_q   <= '0;
            glitch_q <= '0;
            miss_q   <= '0;
            trig_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            good_q   <= good_d;
            have_q   <= have_d;
            last_q   <= last_d;
            glitch_q <= glitch_d;
            miss_q   <= miss_d;
            trig_q   <= trig_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_inc;
        good_d   = good_q;
        have_d   = have_q;
        last_d   = last_q;
        glitch_d = glitch_q;
        miss_d   = miss_q;
        trig_d   = 1'b0;
        unique case (state_q)
            ACQUIRE: begin
                if (edge_det) begin
                    cnt_d = ONE;
                    if (!have_q) begin
                        have_d = 1'b1;
                        good_d = '0;
                    end else begin
                        last_d = cnt_q;
                        if (!in_window) begin
                            good_d = '0;
                        end else if (good_inc == LOCK_N) begin
                            good_d  = good_inc;
                            trig_d  = 1'b1;
                            state_d = LOCKED;
                        end else begin
                            good_d = good_inc;
                        end
                    end
                end
            end
            LOCKED: begin
                // Timeout outranks a coincident edge. Reloading TOL+2
                // keeps cnt aligned to where the missed edge should be.
                if (cnt_q == T_OUT) begin
                    trig_d  = 1'b1;
                    miss_d  = sat_inc8(miss_q);
                    cnt_d   = T_RLD;
                    state_d = HOLDOVER;
                end else if (edge_det) begin
                    if (in_window) begin
                        last_d = cnt_q;
                        cnt_d  = ONE;
                        trig_d = 1'b1;
                    end else if (cnt_q < WIN_LO) begin
                        glitch_d = sat_inc8(glitch_q);
                    end
                end
            end
            HOLDOVER: begin
                if (edge_det) begin
                    last_d  = cnt_q;
                    cnt_d   = ONE;
                    good_d  = '0;
                    state_d = ACQUIRE;
                end else if (cnt_q == NOMINAL) begin
                    trig_d = 1'b1;
                    cnt_d  = ONE;
                end
            end
            default: begin
                state_d = ACQUIRE;
            end
        endcase
    end

    pps_pulse_gen #(
        .PULSE_W (PULSE_W)
    ) u_pulse (
        .clk     (clk),
        .rst     (rst),
        .trig_i  (trig_q),
        .pulse_o (pulse),
        .busy_o  (pulse_busy)
    );

    a_trig_idle: assert property (
        @(posedge clk) disable iff (rst) !(trig_q && pulse_busy)
    );

    assign bus.pps_out       = pulse;
    assign bus.locked        = (state_q == LOCKED);
    assign bus.holdover      = (state_q == HOLDOVER);
    assign bus.last_interval = last_q;
    assign bus.glitch_cnt    = glitch_q;
    assign bus.miss_cnt      = miss_q;

endmodule

// File: tb/tb_pps_qualifier.sv
// Bench for pps_qualifier: directed scenarios with randomized timing,
// every cycle compared against a timestamp-based reference model.
module tb_pps_qualifier;
    localparam int C  = 100;
    localparam int T  = 2;
    localparam int L  = 3;
    localparam int W  = 10;
    localparam int CW = 20;

    localparam int M_ACQ  = 0;
    localparam int M_LOCK = 1;
    localparam int M_HOLD = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    pps_qualifier_if #(.CNT_W(CW)) bus ();

    pps_qualifier #(
        .CLKS_PER_SEC (C),
        .TOL          (T),
        .LOCK_COUNT   (L),
        .PULSE_W      (W),
        .CNT_W        (CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int hi_left = 0;
    int edge_q[$];

    // Reference model: time is absolute cycle number; the interval
    // counter is "cycles since m_anchor".
    int m_mode, m_good, m_anchor, m_last, m_gl, m_mi;
    int p_start, p_end;
    bit m_have, m_pend;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)",
                   tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_mode = M_ACQ; m_good = 0; m_last = 0; m_gl = 0; m_mi = 0;
        m_have = 0; m_pend = 1; m_anchor = 0;
        p_start = 1; p_end = 0;
        edge_q.delete();
    endtask

    task automatic fire();
        if (cyc + 1 > p_end) begin
            p_start = cyc + 1;
            p_end   = cyc + W;
        end
    endtask

    task automatic model_step();
        bit e;
        int n;
        bit win;
        e = 0;
        if (edge_q.size() > 0 && edge_q[0] == cyc) begin
            e = 1;
            void'(edge_q.pop_front());
        end
        if (rst) begin
            model_reset();
            return;
        end
        if (m_pend) begin
            m_anchor = cyc;
            m_pend = 0;
        end
        n = cyc - m_anchor;
        win = (n >= C - T) && (n <= C + T);
        if (m_mode == M_ACQ) begin
            if (e && !m_have) begin
                m_have = 1; m_anchor = cyc; m_good = 0;
            end else if (e) begin
                m_last = n; m_anchor = cyc;
                m_good = win ? m_good + 1 : 0;
                if (m_good == L) begin
                    fire();
                    m_mode = M_LOCK;
                end
            end
        end else if (m_mode == M_LOCK) begin
            if (n == C + T + 1) begin
                fire();
                m_mi = (m_mi < 255) ? m_mi + 1 : 255;
                m_anchor = cyc - (T + 1);
                m_mode = M_HOLD;
            end else if (e && win) begin
                m_last = n; m_anchor = cyc;
                fire();
            end else if (e && n < C - T) begin
                m_gl = (m_gl < 255) ? m_gl + 1 : 255;
            end
        end else begin
            if (e) begin
                m_last = n; m_anchor = cyc; m_good = 0;
                m_mode = M_ACQ;
            end else if (n == C) begin
                fire();
                m_anchor = cyc;
            end
        end
    endtask

    task automatic check_all();
        chk("pps_out", 32'(bus.pps_out),
            32'((cyc >= p_start && cyc <= p_end) ? 1 : 0));
        chk("locked", 32'(bus.locked), 32'((m_mode == M_LOCK) ? 1 : 0));
        chk("holdover", 32'(bus.holdover),
            32'((m_mode == M_HOLD) ? 1 : 0));
        chk("last_interval", 32'(bus.last_interval), m_last);
        chk("glitch_cnt", 32'(bus.glitch_cnt), m_gl);
        chk("miss_cnt", 32'(bus.miss_cnt), m_mi);
    endtask

    // One clock: optionally raise pps_raw (held one cycle high).
    task automatic tick(input bit rise);
        @(negedge clk);
        if (rise) begin
            bus.pps_raw = 1'b1;
            hi_left = 1;
            edge_q.push_back(cyc + 3);
        end else if (hi_left > 0) begin
            hi_left--;
            if (hi_left == 0) bus.pps_raw = 1'b0;
        end
        @(posedge clk);
        cyc++;
        model_step();
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0);
    endtask

    // Raise pps_raw now; the next gap() call rises n cycles later.
    task automatic gap(input int n);
        tick(1'b1);
        idle(n - 1);
    endtask

    initial begin
        bus.pps_raw = 1'b0;
        model_reset();
        #1;
        check_all();
        idle(3);
        rst = 1'b0;
        idle($urandom_range(2, 30));

        // Lock after three good intervals.
        gap(100); gap(100); gap(100);
        chk("pre_lock", 32'(bus.locked), 0);
        gap(100);
        chk("lock_4th", 32'(bus.locked), 1);
        chk("lock_last", 32'(bus.last_interval), 100);

        // Window edges and glitch.
        gap(98); gap(102); gap(97);
        chk("win_102", 32'(bus.last_interval), 102);
        gap(3);
        chk("glitch", 32'(bus.glitch_cnt), 1);
        gap(100);
        chk("post_glitch", 32'(bus.last_interval), 100);
        for (int i = 0; i < 4; i++) gap(C - T + $urandom_range(0, 2 * T));

        // Missing edges: holdover free-run.
        gap(100);
        idle(10);
        chk("hold_flag", 32'(bus.holdover), 1);
        chk("hold_miss", 32'(bus.miss_cnt), 1);
        idle(250 + $urandom_range(0, 60));

        // Recovery.
        gap(100);
        chk("recov_lk", 32'(bus.locked), 0);
        chk("recov_ho", 32'(bus.holdover), 0);
        gap(100); gap(100); gap(100);
        chk("relock", 32'(bus.locked), 1);

        // Async reset three cycles into a pulse.
        tick(1'b1);
        idle(5);
        chk("pulse_on", 32'(bus.pps_out), 1);
        #2 rst = 1'b1;
        #1;
        chk("rst_pps", 32'(bus.pps_out), 0);
        chk("rst_lock", 32'(bus.locked), 0);
        chk("rst_last", 32'(bus.last_interval), 0);
        chk("rst_miss", 32'(bus.miss_cnt), 0);
        chk("rst_glitch", 32'(bus.glitch_cnt), 0);
        model_reset();
        idle(3);
        rst = 1'b0;
        idle($urandom_range(3, 20));

        // Bad acquisition: 100,100,120,100,100,100.
        gap(100); gap(100); gap(120); gap(100); gap(100); gap(100);
        chk("bad_acq", 32'(bus.locked), 0);
        gap(20);
        chk("bad_lock", 32'(bus.locked), 1);
        chk("bad_last", 32'(bus.last_interval), 100);
        idle(50);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
